// File: rtl/call_return_sequencer.sv
// CALL/RET sequencer driving the return-address LIFO; redirects fetch and stalls while busy.
// Optional CALLRET_DEPTH_TRACK_EN adds a shadow occupancy count (depth) and err_desync.
module call_return_sequencer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RETURN_OFFSET  = 1,
  parameter int unsigned STACK_CAPACITY = 31
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  sig_call,
  input  logic                  sig_ret,
  input  logic [DATA_WIDTH-1:0] pc_current,
  input  logic [DATA_WIDTH-1:0] call_target,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [DATA_WIDTH-1:0] stk_data_in,
  input  logic [DATA_WIDTH-1:0] stk_data_out,
  input  logic                  stk_full,
  input  logic                  stk_empty,
  output logic [DATA_WIDTH-1:0] pc_next,
  output logic                  pc_next_valid,
  output logic                  busy,
`ifdef CALLRET_DEPTH_TRACK_EN
  output logic [5:0]            depth,
  output logic                  err_desync,
`endif
  output logic                  err_overflow,
  output logic                  err_underflow
);

  typedef enum logic [1:0] {IDLE, PUSH, POP, CAPTURE} state_t;

  state_t                state_reg, state_next;
  logic                  push_reg, push_next;
  logic                  pop_reg, pop_next;
  logic [DATA_WIDTH-1:0] data_in_reg, data_in_next;
  logic [DATA_WIDTH-1:0] pc_next_reg, pc_next_next;
  logic                  valid_reg, valid_next;
  logic                  busy_reg, busy_next;
  logic                  ovf_reg, ovf_next;
  logic                  unf_reg, unf_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      push_reg    <= 1'b0;
      pop_reg     <= 1'b0;
      data_in_reg <= '0;
      pc_next_reg <= '0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
      unf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      push_reg    <= push_next;
      pop_reg     <= pop_next;
      data_in_reg <= data_in_next;
      pc_next_reg <= pc_next_next;
      valid_reg   <= valid_next;
      busy_reg    <= busy_next;
      ovf_reg     <= ovf_next;
      unf_reg     <= unf_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    push_next    = 1'b0;
    pop_next     = 1'b0;
    data_in_next = data_in_reg;
    pc_next_next = pc_next_reg;
    valid_next   = 1'b0;
    busy_next    = 1'b0;
    ovf_next     = ovf_reg;
    unf_next     = unf_reg;
    case (state_reg)
      IDLE: begin
        // CALL has priority; a simultaneous RET is dropped
        if (sig_call) begin
          if (!stk_full) begin
            state_next   = PUSH;
            push_next    = 1'b1;
            data_in_next = pc_current + DATA_WIDTH'(RETURN_OFFSET);
            pc_next_next = call_target;
            valid_next   = 1'b1;
            busy_next    = 1'b1;
          end else begin
            ovf_next = 1'b1;
          end
        end else if (sig_ret) begin
          if (!stk_empty) begin
            state_next = POP;
            pop_next   = 1'b1;
            busy_next  = 1'b1;
          end else begin
            unf_next = 1'b1;
          end
        end
      end
      PUSH: state_next = IDLE;
      POP: begin
        state_next = CAPTURE;
        valid_next = 1'b1;
        busy_next  = 1'b1;
      end
      CAPTURE: begin
        state_next   = IDLE;
        pc_next_next = stk_data_out;
      end
    endcase
  end

  assign stk_push      = push_reg;
  assign stk_pop       = pop_reg;
  assign stk_data_in   = data_in_reg;
  // The popped word only appears on DataOut after the POP edge, so CAPTURE forwards
  // the LIFO's registered output directly under a registered state select.
  assign pc_next       = (state_reg == CAPTURE) ? stk_data_out : pc_next_reg;
  assign pc_next_valid = valid_reg;
  assign busy          = busy_reg;
  assign err_overflow  = ovf_reg;
  assign err_underflow = unf_reg;

`ifdef CALLRET_DEPTH_TRACK_EN
  localparam logic [5:0] CAP = 6'(STACK_CAPACITY);

  logic [5:0] depth_reg, depth_next;
  logic       desync_reg, desync_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      depth_reg  <= '0;
      desync_reg <= 1'b0;
    end else begin
      depth_reg  <= depth_next;
      desync_reg <= desync_next;
    end
  end

  always_comb begin
    depth_next  = depth_reg;
    desync_next = desync_reg;
    if (state_reg == PUSH && depth_reg != CAP)
      depth_next = depth_reg + 6'd1;
    else if (state_reg == POP && depth_reg != 6'd0)
      depth_next = depth_reg - 6'd1;
    if (state_reg == IDLE &&
        (((depth_reg == 6'd0) != stk_empty) || ((depth_reg == CAP) != stk_full)))
      desync_next = 1'b1;
  end

  assign depth      = depth_reg;
  assign err_desync = desync_reg;
`endif

endmodule

// File: tb/tb_call_return_sequencer.sv
// Randomized scoreboard bench for call_return_sequencer with a behavioural LIFO and
// a queue-based return-address reference model.
module tb_call_return_sequencer;
  localparam int DW  = 32;
  localparam int CAP = 31;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          sig_call, sig_ret;
  logic [DW-1:0] pc_current, call_target;
  logic          stk_push, stk_pop;
  logic [DW-1:0] stk_data_in, stk_data_out;
  logic          stk_full, stk_empty;
  logic [DW-1:0] pc_next;
  logic          pc_next_valid, busy, err_overflow, err_underflow;
`ifdef CALLRET_DEPTH_TRACK_EN
  logic [5:0]    depth;
  logic          err_desync;
  bit            depth_ok = 1'b1;
`endif

  always #5 clock = ~clock;

  call_return_sequencer #(.DATA_WIDTH(DW), .RETURN_OFFSET(1), .STACK_CAPACITY(CAP)) dut (
    .clock(clock), .reset_n(reset_n), .sig_call(sig_call), .sig_ret(sig_ret),
    .pc_current(pc_current), .call_target(call_target),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
    .stk_data_out(stk_data_out), .stk_full(stk_full), .stk_empty(stk_empty),
    .pc_next(pc_next), .pc_next_valid(pc_next_valid), .busy(busy),
`ifdef CALLRET_DEPTH_TRACK_EN
    .depth(depth), .err_desync(err_desync),
`endif
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  // Behavioural 32-entry LIFO: registered DataOut updated on pop, not reset by the DUT.
  logic [DW-1:0] lifo_mem [32];
  logic [5:0]    lifo_ptr  = 6'd0;
  logic [DW-1:0] lifo_dout = '0;
  assign stk_full     = (lifo_ptr == 6'd31);
  assign stk_empty    = (lifo_ptr == 6'd0);
  assign stk_data_out = lifo_dout;
  always @(posedge clock) begin
    if (stk_push && lifo_ptr < 6'd32) begin
      lifo_mem[lifo_ptr[4:0]] <= stk_data_in;
      lifo_ptr <= lifo_ptr + 6'd1;
    end else if (stk_pop && lifo_ptr != 6'd0) begin
      lifo_dout <= lifo_mem[5'(lifo_ptr - 6'd1)];
      lifo_ptr  <= lifo_ptr - 6'd1;
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit            is_call;
    logic [DW-1:0] pc;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_stk[$];
  bit            exp_ovf = 1'b0, exp_unf = 1'b0;
  int            checks = 0, passes = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: pops the expected response whenever the DUT strobes a redirect.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (stk_pop) begin
        chk("pop_exclusive", {31'd0, stk_push}, 0);
        if (exp_q.size() == 0) chk("pop_expected", 1, 0);
        else chk("pop_expected", {31'd0, exp_q[0].is_call}, 0);
      end
      if (pc_next_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_redirect", pc_next, 'x);
        end else begin
          e = exp_q.pop_front();
          chk("redirect_pc", pc_next, e.pc);
          chk("redirect_cycle", cyc, e.cyc);
          if (e.is_call) begin
            chk("push_strobe", {31'd0, stk_push}, 1);
            chk("push_data", stk_data_in, e.data);
          end else begin
            chk("capture_no_pop", {31'd0, stk_pop}, 0);
          end
        end
      end else if (stk_push) begin
        chk("push_without_redirect", 1, 0);
      end
    end
  end

  task automatic op(input bit c, input bit r, input logic [DW-1:0] pc, input logic [DW-1:0] tgt);
    exp_t e;
    int   nb, exp_nb;
    exp_nb = 0;
    @(negedge clock);
    if (c) begin
      if (ref_stk.size() == CAP) exp_ovf = 1'b1;
      else begin
        ref_stk.push_back(pc + 32'd1);
        e.is_call = 1'b1; e.pc = tgt; e.data = pc + 32'd1; e.cyc = cyc + 1;
        exp_q.push_back(e);
        exp_nb = 1;
      end
    end else if (r) begin
      if (ref_stk.size() == 0) exp_unf = 1'b1;
      else begin
        e.is_call = 1'b0; e.pc = ref_stk.pop_back(); e.data = '0; e.cyc = cyc + 2;
        exp_q.push_back(e);
        exp_nb = 2;
      end
    end
    sig_call = c; sig_ret = r; pc_current = pc; call_target = tgt;
    @(posedge clock); #1;
    sig_call = 1'b0; sig_ret = 1'b0;
    nb = 0;
    repeat (4) begin
      if (busy) nb++;
      @(posedge clock); #1;
    end
    chk("busy_cycles", nb, exp_nb);
    chk("err_overflow", {31'd0, err_overflow}, {31'd0, exp_ovf});
    chk("err_underflow", {31'd0, err_underflow}, {31'd0, exp_unf});
`ifdef CALLRET_DEPTH_TRACK_EN
    if (depth_ok) begin
      chk("depth", DW'(depth), DW'(ref_stk.size()));
      chk("err_desync", {31'd0, err_desync}, 0);
    end
`endif
    $display("txn call=%0b ret=%0b pc=0x%08h tgt=0x%08h stack=%0d", c, r, pc, tgt, ref_stk.size());
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; sig_call = 1'b0; sig_ret = 1'b0; pc_current = '0; call_target = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_push", {31'd0, stk_push}, 0);
    chk("rst_pop", {31'd0, stk_pop}, 0);
    chk("rst_data_in", stk_data_in, 0);
    chk("rst_pc_next", pc_next, 0);
    chk("rst_valid", {31'd0, pc_next_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_errs", {30'd0, err_overflow, err_underflow}, 0);
    @(negedge clock) reset_n = 1'b1;

    op(1, 0, 32'h100, 32'h400);
    op(0, 1, 0, 0);
    op(0, 1, 0, 0);                       // underflow on empty stack
    op(1, 1, 32'h200, 32'h800);           // CALL wins over RET
    op(0, 1, 0, 0);
    op(1, 0, 32'h10, 32'h1000);
    op(1, 0, 32'h20, 32'h2000);
    op(1, 0, 32'h30, 32'h3000);
    repeat (3) op(0, 1, 0, 0);

    for (int i = 1; i <= CAP; i++) op(1, 0, DW'(i * 16), DW'(32'h8000 + i));
    chk("full_seen", {31'd0, stk_full}, 1);
    op(1, 0, 32'hDEAD, 32'hBEEF);         // overflow: no push, no redirect
    op(0, 1, 0, 0);

    for (int i = 0; i < 150; i++) begin
      int unsigned k;
      k = $urandom_range(0, 99);
      if (k < 45)      op(1, 0, $urandom, $urandom);
      else if (k < 90) op(0, 1, $urandom, $urandom);
      else             op(1, 1, $urandom, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    // Reset pulsed in the middle of a POP: the strobe must not reach the LIFO.
    op(1, 0, 32'h5550, 32'h6000);
    @(negedge clock);
    sig_ret = 1'b1;
    @(posedge clock); #1;
    sig_ret = 1'b0;
    chk("pop_before_reset", {31'd0, stk_pop}, 1);
    #1 reset_n = 1'b0;
`ifdef CALLRET_DEPTH_TRACK_EN
    depth_ok = 1'b0;
`endif
    #1;
    chk("async_rst_pop", {31'd0, stk_pop}, 0);
    chk("async_rst_busy", {31'd0, busy}, 0);
    chk("async_rst_valid", {31'd0, pc_next_valid}, 0);
    #1 reset_n = 1'b1;
    exp_ovf = 1'b0; exp_unf = 1'b0;
    repeat (3) @(negedge clock);
    op(0, 1, 0, 0);                       // the aborted pop left the top entry in place

    repeat (4) @(negedge clock);
    chk("queue_drained", DW'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/call_return_sequencer.md
Name: call_return_sequencer

Overview:
- Client-side driver for the processor's 32-entry return-address LIFO. It owns `sig_push`, `sig_pop` and `DataIn`, and consumes `DataOut`, `flag_full` and `flag_empty`.
- Turns decoded CALL/RET requests from the control unit into push/pop sequences.
- Presents the next PC to the fetch stage and stalls the pipeline while a sequence is in progress.
- Detects stack overflow and underflow.

Parameters:
- DATA_WIDTH, 32, return-address width. Must equal the LIFO word width.
- RETURN_OFFSET, 1, value added to `pc_current` to form the pushed return address.
- STACK_CAPACITY, 31, usable LIFO entries. `flag_full` asserts at pointer 31.

Ports:
- clock  in  1  rising-edge clock, shared with the LIFO
- reset_n  in  1  asynchronous active-low reset
- sig_call  in  1  CALL decoded, single-cycle pulse
- sig_ret  in  1  RET decoded, single-cycle pulse
- pc_current  in  DATA_WIDTH  PC of the CALL instruction
- call_target  in  DATA_WIDTH  CALL destination address
- stk_push  out  1  drives LIFO `sig_push`
- stk_pop  out  1  drives LIFO `sig_pop`
- stk_data_in  out  DATA_WIDTH  drives LIFO `DataIn`
- stk_data_out  in  DATA_WIDTH  LIFO `DataOut`
- stk_full  in  1  LIFO `flag_full`
- stk_empty  in  1  LIFO `flag_empty`
- pc_next  out  DATA_WIDTH  redirect address
- pc_next_valid  out  1  one-cycle strobe: fetch loads `pc_next`
- busy  out  1  stall request to the control unit
- err_overflow  out  1  sticky: CALL attempted while full
- err_underflow  out  1  sticky: RET attempted while empty

Behaviour:
- Reset: all outputs 0 and FSM in IDLE, asynchronously on `reset_n` low. LIFO contents and pointer are not reset by this block.
- All outputs are registered. Requests are sampled only in IDLE. `sig_call` / `sig_ret` arriving while `busy` is high are ignored; the control unit must hold off.
- States: IDLE, PUSH, POP, CAPTURE.
- IDLE with `sig_call` and `!stk_full`:
  - next state PUSH.
  - In PUSH: `stk_push` = 1, `stk_data_in` = `pc_current` + RETURN_OFFSET (mod 2^DATA_WIDTH), `pc_next` = `call_target`, `pc_next_valid` = 1, `busy` = 1.
  - PUSH → IDLE.
  - CALL latency: 1 cycle from request to redirect.
- IDLE with `sig_call` and `stk_full`:
  - `err_overflow` ← 1; no push, no redirect.
  - Stay IDLE.
- IDLE with `sig_ret` and `!stk_empty`:
  - next state POP.
  - In POP: `stk_pop` = 1, `busy` = 1. The LIFO updates `DataOut` on the closing edge.
  - POP → CAPTURE.
  - In CAPTURE: `pc_next` = `stk_data_out`, `pc_next_valid` = 1, `busy` = 1.
  - CAPTURE → IDLE.
  - RET latency: 2 cycles from request to redirect.
- IDLE with `sig_ret` and `stk_empty`: `err_underflow` ← 1; no pop, no redirect.
- `sig_call` and `sig_ret` both high in IDLE: CALL wins and RET is dropped.
- `stk_push` and `stk_pop` are never high in the same cycle.
- `stk_data_in` holds its last value outside PUSH.
- Error flags are cleared only by reset.
- Reset mid-sequence: the FSM aborts to IDLE immediately.
  - A PUSH or POP strobe cut by reset before a rising edge has no LIFO effect.
  - Redirects after reset are only guaranteed if the LIFO is also reinitialised.

Optional Feature:
- Macro: `CALLRET_DEPTH_TRACK_EN`.
- When defined:
  - Adds output `depth` [5:0], a shadow count of LIFO occupancy. Reset 0, +1 on each PUSH cycle, −1 on each POP cycle, saturating 0..STACK_CAPACITY.
  - Adds sticky output `err_desync`, set when `(depth == 0) != stk_empty` or `(depth == STACK_CAPACITY) != stk_full`. Checked in IDLE only.
- When undefined: neither port nor its logic exists, and behaviour is otherwise identical.

Test Plan:
- Reset, then `sig_call` with `pc_current` = 0x100, `call_target` = 0x400 → next cycle `stk_push` = 1, `stk_data_in` = 0x101, `pc_next` = 0x400, `pc_next_valid` = 1.
- After that CALL, pulse `sig_ret` → cycle+1 `stk_pop` = 1; cycle+2 `pc_next` = 0x101, `pc_next_valid` = 1; `busy` high for exactly 2 cycles.
- Nested: CALL from 0x10, 0x20, 0x30, then 3 RETs → redirects 0x31, 0x21, 0x11 in order.
- 31 CALLs, then a 32nd → `stk_full` seen, no `stk_push` on the 32nd, `err_overflow` = 1. A subsequent RET still returns the 31st address.
- RET after reset on an empty LIFO → `err_underflow` = 1, `stk_pop` stays 0, no `pc_next_valid`. Simultaneous `sig_call` + `sig_ret` → only the push occurs.
- `reset_n` pulsed low during POP → outputs 0 asynchronously, FSM in IDLE, no `pc_next_valid`.
  - With `CALLRET_DEPTH_TRACK_EN` defined, `depth` counts 0→3→0 across the nested case.
